sdram_frame_reader: RTL and testbench

- Read-side counterpart of the HDMI capture path.
- Walks a stored frame in SDRAM in fixed-length bursts through a req/ack read port to the SDRAM controller.
- Buffers returned words in an internal FIFO and streams 24-bit RGB words to the voxel display pipeline over a valid/ready interface.
- Runs entirely in the SDRAM clock domain; consumer-side CDC is out of scope.

---
 rtl/sdram_frame_reader.sv | 213 +++++++++++++++++++++
 tb/tb_sdram_frame_reader.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_frame_reader.sv
// SDRAM frame reader: walks a stored frame in fixed-length read bursts, buffers the
// returned beats in a first-word-fall-through FIFO and streams them out over valid/ready.
// Everything runs in the SDRAM clock domain.
// Optional feature macro: SDRAM_FRAME_READER_ERR_EN adds a sticky rd_err_o flag for
// stray or overflowing read beats.
module sdram_frame_reader #(
    parameter int unsigned ADDR_W      = 13,
    parameter int unsigned BANK_W      = 2,
    parameter int unsigned DATA_W      = 24,
    parameter int unsigned FRAME_WORDS = 8192,
    parameter int unsigned BURST_LEN   = 4,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic              sdram_clk_i,
    input  logic              n_reset_i,
    input  logic              read_enable_i,
    input  logic [BANK_W-1:0] frame_bank_i,
    output logic              rd_req_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [BANK_W-1:0] rd_bank_o,
    input  logic              rd_ack_i,
    input  logic              rd_valid_i,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic [DATA_W-1:0] pix_data_o,
    output logic              pix_valid_o,
    input  logic              pix_ready_i,
    output logic              frame_start_o,
    output logic              frame_done_o
`ifdef SDRAM_FRAME_READER_ERR_EN
    ,
    output logic              rd_err_o
`endif
);

    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BEAT_W = $clog2(BURST_LEN + 1);

    localparam logic [ADDR_W-1:0] LastBurstAddr = ADDR_W'(FRAME_WORDS - BURST_LEN);
    localparam logic [ADDR_W-1:0] BurstStep     = ADDR_W'(BURST_LEN);
    localparam logic [CNT_W-1:0]  DepthCnt      = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  BurstCnt      = CNT_W'(BURST_LEN);
    localparam logic [BEAT_W-1:0] LastBeat      = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWaitSpace,
        StReq,
        StRecv,
        StFrameEnd
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BANK_W-1:0]   bank_q, bank_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                frame_start_q, frame_start_d;

    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic in_recv;
    logic recv_beat;
    logic full;
    logic push;
    logic pop;

    assign in_recv   = (state_q == StRecv);
    // A beat counts towards the burst even if it had to be dropped, so the FSM stays in
    // step with the controller.
    assign recv_beat = in_recv & rd_valid_i;
    assign full      = (count_q == DepthCnt);
    assign push      = recv_beat & ~full;
    assign pop       = pix_valid_o & pix_ready_i;

    // Next-state logic for the burst walker.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        bank_d        = bank_q;
        beat_d        = beat_q;
        frame_start_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (read_enable_i) begin
                    state_d       = StWaitSpace;
                    addr_d        = '0;
                    bank_d        = frame_bank_i;
                    frame_start_d = 1'b1;
                end
            end
            StWaitSpace: begin
                // Reserve room for the whole burst so returned beats can never overflow.
                if ((DepthCnt - count_q) >= BurstCnt) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (rd_ack_i) begin
                    beat_d  = '0;
                    state_d = StRecv;
                end
            end
            StRecv: begin
                if (recv_beat) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (beat_q == LastBeat) begin
                        if (addr_q == LastBurstAddr) begin
                            addr_d  = '0;
                            state_d = StFrameEnd;
                        end else begin
                            addr_d  = addr_q + BurstStep;
                            state_d = read_enable_i ? StWaitSpace : StIdle;
                        end
                    end
                end
            end
            StFrameEnd: begin
                if (read_enable_i) begin
                    state_d       = StWaitSpace;
                    addr_d        = '0;
                    bank_d        = frame_bank_i;
                    frame_start_d = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM and address registers.
    always_ff @(posedge sdram_clk_i or negedge n_reset_i) begin
        if (!n_reset_i) begin
            state_q       <= StIdle;
            addr_q        <= '0;
            bank_q        <= '0;
            beat_q        <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            bank_q        <= bank_d;
            beat_q        <= beat_d;
            frame_start_q <= frame_start_d;
        end
    end

    // FIFO pointer and occupancy update; push and pop may coincide.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // FIFO control registers.
    always_ff @(posedge sdram_clk_i or negedge n_reset_i) begin
        if (!n_reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge sdram_clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= rd_data_i;
        end
    end

    assign rd_req_o      = (state_q == StReq);
    assign rd_addr_o     = addr_q;
    assign rd_bank_o     = bank_q;
    assign frame_start_o = frame_start_q;
    assign frame_done_o  = (state_q == StFrameEnd);
    assign pix_valid_o   = (count_q != '0);
    // Masked while empty so the output reads zero out of reset.
    assign pix_data_o    = pix_valid_o ? mem_q[rd_ptr_q] : '0;

`ifdef SDRAM_FRAME_READER_ERR_EN
    logic err_q;

    // Sticky flag for beats that arrive outside a burst or into a full FIFO.
    always_ff @(posedge sdram_clk_i or negedge n_reset_i) begin
        if (!n_reset_i) begin
            err_q <= 1'b0;
        end else if (rd_valid_i && (!in_recv || full)) begin
            err_q <= 1'b1;
        end
    end

    assign rd_err_o = err_q;
`endif

endmodule

// File: tb/tb_sdram_frame_reader.sv
// Directed bench for sdram_frame_reader: small frame (16 words, bursts of 4, FIFO of 8),
// a behavioural SDRAM controller that acks one cycle after a request and returns data
// two cycles after the ack, and a monitor logging popped pixels and frame pulses.
module tb_sdram_frame_reader;

    localparam int unsigned ADDR_W = 13;
    localparam int unsigned BANK_W = 2;
    localparam int unsigned DATA_W = 24;

    logic              clk;
    logic              n_reset;
    logic              read_enable;
    logic [BANK_W-1:0] frame_bank;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [BANK_W-1:0] rd_bank;
    logic              rd_ack;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic              frame_start;
    logic              frame_done;
`ifdef SDRAM_FRAME_READER_ERR_EN
    logic              rd_err;
`endif

    logic              ctrl_valid;
    logic [DATA_W-1:0] ctrl_data;
    logic              tb_valid;
    logic [DATA_W-1:0] tb_data;
    logic              ctrl_busy;
    int                ctrl_beat;
    int                budget;

    logic [DATA_W-1:0] got_q[$];
    int                start_pos_q[$];
    logic [BANK_W-1:0] start_bank_q[$];
    int                done_pos_q[$];
    logic [BANK_W-1:0] done_bank_q[$];
    logic [ADDR_W-1:0] req_addr_q[$];
    logic [ADDR_W-1:0] ack_addr_q[$];
    logic [BANK_W-1:0] req_bank_q[$];

    int n_checks;
    int n_fail;

    assign rd_valid = ctrl_valid | tb_valid;
    assign rd_data  = tb_valid ? tb_data : ctrl_data;

    sdram_frame_reader #(
        .ADDR_W      (ADDR_W),
        .BANK_W      (BANK_W),
        .DATA_W      (DATA_W),
        .FRAME_WORDS (16),
        .BURST_LEN   (4),
        .FIFO_DEPTH  (8)
    ) dut (
        .sdram_clk_i   (clk),
        .n_reset_i     (n_reset),
        .read_enable_i (read_enable),
        .frame_bank_i  (frame_bank),
        .rd_req_o      (rd_req),
        .rd_addr_o     (rd_addr),
        .rd_bank_o     (rd_bank),
        .rd_ack_i      (rd_ack),
        .rd_valid_i    (rd_valid),
        .rd_data_i     (rd_data),
        .pix_data_o    (pix_data),
        .pix_valid_o   (pix_valid),
        .pix_ready_i   (pix_ready),
        .frame_start_o (frame_start),
        .frame_done_o  (frame_done)
`ifdef SDRAM_FRAME_READER_ERR_EN
        ,
        .rd_err_o      (rd_err)
`endif
    );

    // Stored frame content: a tag, the bank and the word address.
    function automatic logic [DATA_W-1:0] pix_word(input logic [BANK_W-1:0] b, input int a);
        logic [7:0] lo;
        lo = a[7:0];
        return {8'hC3, 6'd0, b, lo};
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural SDRAM controller serving up to 'budget' requests.
    initial begin
        logic [ADDR_W-1:0] seen_addr;
        logic [BANK_W-1:0] seen_bank;
        rd_ack     = 1'b0;
        ctrl_valid = 1'b0;
        ctrl_data  = '0;
        ctrl_busy  = 1'b0;
        ctrl_beat  = 0;
        forever begin
            @(negedge clk);
            if (n_reset && rd_req && budget > 0) begin
                ctrl_busy = 1'b1;
                budget    = budget - 1;
                seen_addr = rd_addr;
                seen_bank = rd_bank;
                @(posedge clk); #1 rd_ack = 1'b1;
                @(negedge clk);
                ack_addr_q.push_back(rd_addr);
                req_addr_q.push_back(seen_addr);
                req_bank_q.push_back(seen_bank);
                @(posedge clk); #1 rd_ack = 1'b0;
                @(posedge clk); #1;
                for (int i = 0; i < 4; i++) begin
                    ctrl_valid = 1'b1;
                    ctrl_beat  = i;
                    ctrl_data  = pix_word(seen_bank, int'(seen_addr) + i);
                    @(posedge clk); #1;
                end
                ctrl_valid = 1'b0;
                ctrl_beat  = 0;
                ctrl_busy  = 1'b0;
            end
        end
    end

    // Output monitor: pops first, then frame pulses, so positions count this cycle's pop.
    initial begin
        forever begin
            @(negedge clk);
            if (n_reset) begin
                if (pix_valid && pix_ready) got_q.push_back(pix_data);
                if (frame_start) begin
                    start_pos_q.push_back(got_q.size());
                    start_bank_q.push_back(rd_bank);
                end
                if (frame_done) begin
                    done_pos_q.push_back(got_q.size());
                    done_bank_q.push_back(rd_bank);
                end
            end
        end
    end

    task automatic do_reset();
        budget = 0;
        for (int c = 0; c < 40 && ctrl_busy; c++) @(negedge clk);
        read_enable = 1'b0;
        pix_ready   = 1'b0;
        tb_valid    = 1'b0;
        @(negedge clk);
        n_reset = 1'b0;
        repeat (3) @(negedge clk);
        got_q.delete(); start_pos_q.delete(); start_bank_q.delete();
        done_pos_q.delete(); done_bank_q.delete();
        req_addr_q.delete(); ack_addr_q.delete(); req_bank_q.delete();
        n_reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (rd_req !== 1'b0) begin n_fail++; $display("FAIL reset_rd_req got %0b want 0", rd_req); end
        n_checks++; if (rd_addr !== 13'd0) begin n_fail++; $display("FAIL reset_rd_addr got %0d want 0", rd_addr); end
        n_checks++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pix_valid got %0b want 0", pix_valid); end
        n_checks++; if (pix_data !== 24'd0) begin n_fail++; $display("FAIL reset_pix_data got %h want 0", pix_data); end
        n_checks++; if ({frame_start, frame_done} !== 2'b00) begin n_fail++; $display("FAIL reset_frame_pulses got %b want 00", {frame_start, frame_done}); end
        do_reset();
        n_checks++; if (rd_bank !== 2'd0) begin n_fail++; $display("FAIL reset_rd_bank got %0d want 0", rd_bank); end
    endtask

    task automatic test_stream();
        do_reset();
        frame_bank = 2'd2; pix_ready = 1'b1; budget = 1000; read_enable = 1'b1;
        for (int c = 0; c < 1500 && got_q.size() < 32; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_checks++; if (got_q.size() < 32) begin n_fail++; $display("FAIL stream_timeout got %0d words want 32", got_q.size()); end
        else begin
            for (int k = 0; k < 32; k++) begin
                n_checks++;
                if (got_q[k] !== pix_word(2'd2, k % 16)) begin n_fail++; $display("FAIL stream_word[%0d] got %h want %h", k, got_q[k], pix_word(2'd2, k % 16)); end
            end
        end
        n_checks++; if (req_addr_q.size() < 8) begin n_fail++; $display("FAIL stream_req_count got %0d want >=8", req_addr_q.size()); end
        else begin
            for (int k = 0; k < 8; k++) begin
                n_checks++;
                if (req_addr_q[k] !== 13'(4 * (k % 4)) || ack_addr_q[k] !== req_addr_q[k] || req_bank_q[k] !== 2'd2) begin
                    n_fail++; $display("FAIL stream_req[%0d] addr %0d/%0d bank %0d want addr %0d bank 2", k, req_addr_q[k], ack_addr_q[k], req_bank_q[k], 4 * (k % 4));
                end
            end
        end
        n_checks++; if (start_pos_q.size() !== 3 || start_pos_q[0] !== 0 || start_pos_q[1] !== 16 || start_pos_q[2] !== 32) begin
            n_fail++; $display("FAIL stream_frame_start got %p want '{0,16,32}", start_pos_q); end
        n_checks++; if (done_pos_q.size() !== 2 || done_pos_q[0] !== 16 || done_pos_q[1] !== 32) begin
            n_fail++; $display("FAIL stream_frame_done got %p want '{16,32}", done_pos_q); end
        n_checks++; if (start_bank_q.size() !== 3 || start_bank_q[0] !== 2'd2 || start_bank_q[2] !== 2'd2) begin
            n_fail++; $display("FAIL stream_start_bank got %p want all 2", start_bank_q); end
    endtask

    task automatic test_backpressure();
        int first;
        do_reset();
        frame_bank = 2'd2; pix_ready = 1'b0; budget = 1000; read_enable = 1'b1;
        repeat (60) @(negedge clk);
        n_checks++; if (req_addr_q.size() !== 2) begin n_fail++; $display("FAIL bp_req_count got %0d want 2", req_addr_q.size()); end
        n_checks++; if (rd_req !== 1'b0) begin n_fail++; $display("FAIL bp_rd_req_full got %0b want 0", rd_req); end
        n_checks++; if (pix_valid !== 1'b1 || pix_data !== pix_word(2'd2, 0)) begin
            n_fail++; $display("FAIL bp_head got valid %0b data %h want 1 %h", pix_valid, pix_data, pix_word(2'd2, 0)); end
        @(posedge clk); #1 pix_ready = 1'b1;
        first = -1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (rd_req) begin first = i; break; end
        end
        // Occupancy 8 drops by one per cycle; it reaches 4 in cycle 4, request follows in 5.
        n_checks++; if (first !== 5) begin n_fail++; $display("FAIL bp_third_req_cycle got %0d want 5", first); end
        n_checks++; if (rd_addr !== 13'd8) begin n_fail++; $display("FAIL bp_third_req_addr got %0d want 8", rd_addr); end
        for (int c = 0; c < 200 && got_q.size() < 12; c++) @(negedge clk);
        n_checks++; if (got_q.size() < 12) begin n_fail++; $display("FAIL bp_drain_timeout got %0d words want 12", got_q.size()); end
        else begin
            n_checks++; if (got_q[7] !== pix_word(2'd2, 7) || got_q[11] !== pix_word(2'd2, 11)) begin
                n_fail++; $display("FAIL bp_order got %h %h want %h %h", got_q[7], got_q[11], pix_word(2'd2, 7), pix_word(2'd2, 11)); end
        end
    endtask

    task automatic test_bank_switch();
        do_reset();
        frame_bank = 2'd2; pix_ready = 1'b1; budget = 1000; read_enable = 1'b1;
        for (int c = 0; c < 500 && got_q.size() < 6; c++) @(negedge clk);
        frame_bank = 2'd1;
        @(negedge clk);
        n_checks++; if (rd_bank !== 2'd2) begin n_fail++; $display("FAIL bank_midframe got %0d want 2", rd_bank); end
        for (int c = 0; c < 1000 && got_q.size() < 20; c++) @(negedge clk);
        n_checks++; if (got_q.size() < 20) begin n_fail++; $display("FAIL bank_timeout got %0d words want 20", got_q.size()); end
        else begin
            n_checks++; if (got_q[15] !== pix_word(2'd2, 15) || got_q[16] !== pix_word(2'd1, 0)) begin
                n_fail++; $display("FAIL bank_words got %h %h want %h %h", got_q[15], got_q[16], pix_word(2'd2, 15), pix_word(2'd1, 0)); end
        end
        n_checks++; if (start_bank_q.size() < 2 || start_bank_q[0] !== 2'd2 || start_bank_q[1] !== 2'd1) begin
            n_fail++; $display("FAIL bank_at_start got %p want '{2,1}", start_bank_q); end
        n_checks++; if (done_bank_q.size() < 1 || done_bank_q[0] !== 2'd2) begin
            n_fail++; $display("FAIL bank_at_done got %p want '{2}", done_bank_q); end
        n_checks++; if (req_bank_q.size() < 5 || req_bank_q[3] !== 2'd2 || req_bank_q[4] !== 2'd1) begin
            n_fail++; $display("FAIL bank_req got %p want [3]=2 [4]=1", req_bank_q); end
    endtask

    task automatic test_disable();
        do_reset();
        frame_bank = 2'd3; pix_ready = 1'b1; budget = 1000; read_enable = 1'b1;
        for (int c = 0; c < 500 && !(ctrl_valid && ctrl_beat == 1 && req_addr_q.size() == 2); c++) @(negedge clk);
        read_enable = 1'b0;
        repeat (30) @(negedge clk);
        n_checks++; if (got_q.size() !== 8) begin n_fail++; $display("FAIL dis_word_count got %0d want 8", got_q.size()); end
        else begin
            n_checks++; if (got_q[5] !== pix_word(2'd3, 5) || got_q[7] !== pix_word(2'd3, 7)) begin
                n_fail++; $display("FAIL dis_tail_words got %h %h want %h %h", got_q[5], got_q[7], pix_word(2'd3, 5), pix_word(2'd3, 7)); end
        end
        n_checks++; if (req_addr_q.size() !== 2 || rd_req !== 1'b0) begin
            n_fail++; $display("FAIL dis_no_req got reqs %0d rd_req %0b want 2 0", req_addr_q.size(), rd_req); end
        n_checks++; if (done_pos_q.size() !== 0) begin n_fail++; $display("FAIL dis_no_done got %0d want 0", done_pos_q.size()); end
        @(posedge clk); #1 read_enable = 1'b1;
        for (int c = 0; c < 20 && !rd_req; c++) @(negedge clk);
        n_checks++; if (rd_req !== 1'b1 || rd_addr !== 13'd0) begin
            n_fail++; $display("FAIL dis_restart got rd_req %0b addr %0d want 1 0", rd_req, rd_addr); end
        n_checks++; if (start_pos_q.size() !== 2 || start_pos_q[1] !== 8) begin
            n_fail++; $display("FAIL dis_restart_start got %p want '{0,8}", start_pos_q); end
    endtask

    task automatic test_async_reset();
        do_reset();
        frame_bank = 2'd2; pix_ready = 1'b0; budget = 1; read_enable = 1'b1;
        for (int c = 0; c < 100 && !(budget == 0 && !ctrl_busy && rd_req); c++) @(negedge clk);
        @(posedge clk); #1 pix_ready = 1'b1;
        @(posedge clk); #1 pix_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (rd_req !== 1'b1 || rd_addr !== 13'd4 || pix_valid !== 1'b1) begin
            n_fail++; $display("FAIL ar_pre got rd_req %0b addr %0d pix_valid %0b want 1 4 1", rd_req, rd_addr, pix_valid); end
        n_checks++; if (got_q.size() !== 1 || pix_data !== pix_word(2'd2, 1)) begin
            n_fail++; $display("FAIL ar_pre_fifo got %0d popped head %h want 1 %h", got_q.size(), pix_data, pix_word(2'd2, 1)); end
        #2 n_reset = 1'b0;
        #1;
        n_checks++; if (rd_req !== 1'b0 || pix_valid !== 1'b0 || rd_addr !== 13'd0 || rd_bank !== 2'd0) begin
            n_fail++; $display("FAIL ar_async got rd_req %0b pix_valid %0b addr %0d bank %0d want 0 0 0 0", rd_req, pix_valid, rd_addr, rd_bank); end
        read_enable = 1'b0;
        do_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL ar_fifo_empty got %0b want 0", pix_valid); end
    endtask

    task automatic test_stray_valid();
        do_reset();
`ifdef SDRAM_FRAME_READER_ERR_EN
        n_checks++; if (rd_err !== 1'b0) begin n_fail++; $display("FAIL err_reset got %0b want 0", rd_err); end
`endif
        tb_data = 24'h123456; tb_valid = 1'b1;
        @(posedge clk); #1 tb_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL stray_no_push cycle %0d got %0b want 0", i, pix_valid); end
        end
`ifdef SDRAM_FRAME_READER_ERR_EN
        n_checks++; if (rd_err !== 1'b1) begin n_fail++; $display("FAIL err_set got %0b want 1", rd_err); end
`endif
        frame_bank = 2'd0; pix_ready = 1'b1; budget = 1; read_enable = 1'b1;
        for (int c = 0; c < 100 && got_q.size() < 4; c++) @(negedge clk);
        n_checks++; if (got_q.size() !== 4 || got_q[0] !== pix_word(2'd0, 0)) begin
            n_fail++; $display("FAIL stray_first_word got %0d words head %h want 4 %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 24'd0, pix_word(2'd0, 0)); end
`ifdef SDRAM_FRAME_READER_ERR_EN
        n_checks++; if (rd_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %0b want 1", rd_err); end
`endif
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        n_reset     = 1'b0;
        read_enable = 1'b0;
        frame_bank  = 2'd0;
        pix_ready   = 1'b0;
        tb_valid    = 1'b0;
        tb_data     = '0;
        budget      = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_bank_switch();
        test_disable();
        test_async_reset();
        test_stray_valid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
